// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package pc_fetch_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_BOOT = 3'd0,
    ST_REQ  = 3'd1,
    ST_RESP = 3'd2,
    ST_DROP = 3'd3,
    ST_HALT = 3'd4
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_fetch_buf.sv
// One-entry fetch output register: load from memory response, drain on ready, flush on redirect.
module fetch_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        load,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_instr,
  input  logic        ready,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] instr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      instr <= load_instr;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch sequencer: one outstanding memory request, redirect handling, misalignment halt.
//   state | meaning
//   BOOT  | first cycle after reset release, loads RESET_PC
//   REQ   | request pc when the output buffer can take the answer
//   RESP  | waiting for the response of a granted request
//   DROP  | waiting for a response that a redirect made stale
//   HALT  | misaligned redirect seen, idle until an aligned redirect
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        f_valid,
  output logic [31:0] f_pc,
  output logic [31:0] f_instr,
  input  logic        f_ready,
  output logic        fetch_misaligned
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic         owed_q, owed_d;
  logic         mis_q, mis_d;
  logic         buf_free, grant, buf_load, buf_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_BOOT;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      owed_q   <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      owed_q   <= owed_d;
      mis_q    <= mis_d;
    end
  end

  // owed tracks the single in-flight response independently of state so HALT can still drop it
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    mis_d    = 1'b0;
    owed_d   = (owed_q && !imem_rvalid) || grant;
    if (redirect_valid) begin
      pc_d = redirect_target;
      if (is_misaligned(redirect_target)) begin
        mis_d   = 1'b1;
        state_d = ST_HALT;
      end else begin
        state_d = owed_d ? ST_DROP : ST_REQ;
      end
    end else begin
      case (state_q)
        ST_BOOT: begin
          state_d = ST_REQ;
          pc_d    = RESET_PC;
        end
        ST_REQ: begin
          if (grant) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + PC_STEP;
            state_d  = ST_RESP;
          end
        end
        ST_RESP, ST_DROP: begin
          if (imem_rvalid) state_d = ST_REQ;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    buf_free         = !f_valid || f_ready;
    imem_req         = (state_q == ST_REQ) && buf_free;
    imem_addr        = pc_q;
    grant            = imem_req && imem_gnt;
    buf_flush        = redirect_valid;
    buf_load         = (state_q == ST_RESP) && imem_rvalid && !redirect_valid;
    fetch_misaligned = mis_q;
  end

  fetch_buf u_fetch_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (buf_flush),
    .load       (buf_load),
    .load_pc    (req_pc_q),
    .load_instr (imem_rdata),
    .ready      (f_ready),
    .valid      (f_valid),
    .pc         (f_pc),
    .instr      (f_instr)
  );

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed cycle table, reset-in-flight check, randomized run against a stream model.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        f_valid;
  logic [31:0] f_pc;
  logic [31:0] f_instr;
  logic        f_ready;
  logic        fetch_misaligned;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_gnt         (imem_gnt),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata       (imem_rdata),
    .f_valid          (f_valid),
    .f_pc             (f_pc),
    .f_instr          (f_instr),
    .f_ready          (f_ready),
    .fetch_misaligned (fetch_misaligned)
  );

  typedef struct {
    logic        rd;
    logic [31:0] tgt;
    logic        gnt;
    logic        rv;
    logic [31:0] rva;
    logic        fr;
    logic        ereq;
    logic [31:0] eaddr;
    logic        efv;
    logic [31:0] efpc;
    logic        emis;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic vec_t mk(input logic rd, input logic [31:0] tgt, input logic gnt,
                              input logic rv, input logic [31:0] rva, input logic fr,
                              input logic ereq, input logic [31:0] eaddr, input logic efv,
                              input logic [31:0] efpc, input logic emis);
    vec_t v;
    v.rd = rd; v.tgt = tgt; v.gnt = gnt; v.rv = rv; v.rva = rva; v.fr = fr;
    v.ereq = ereq; v.eaddr = eaddr; v.efv = efv; v.efpc = efpc; v.emis = emis;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    redirect_valid  = 1'b0;
    redirect_target = '0;
    imem_gnt        = 1'b0;
    imem_rvalid     = 1'b0;
    imem_rdata      = '0;
    f_ready         = 1'b0;
  endtask

  task automatic apply_row(input vec_t v, input int idx);
    redirect_valid  = v.rd;
    redirect_target = v.tgt;
    imem_gnt        = v.gnt;
    imem_rvalid     = v.rv;
    imem_rdata      = v.rv ? mem_word(v.rva) : 32'hDEAD_BEEF;
    f_ready         = v.fr;
    #1;
    chk($sformatf("row%0d imem_req", idx), 32'(imem_req), 32'(v.ereq));
    chk($sformatf("row%0d imem_addr", idx), imem_addr, v.eaddr);
    chk($sformatf("row%0d f_valid", idx), 32'(f_valid), 32'(v.efv));
    chk($sformatf("row%0d fetch_misaligned", idx), 32'(fetch_misaligned), 32'(v.emis));
    if (v.efv) begin
      chk($sformatf("row%0d f_pc", idx), f_pc, v.efpc);
      chk($sformatf("row%0d f_instr", idx), f_instr, mem_word(v.efpc));
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " imem_req"}, 32'(imem_req), 32'd0);
    chk({tag, " imem_addr"}, imem_addr, RST_PC);
    chk({tag, " f_valid"}, 32'(f_valid), 32'd0);
    chk({tag, " f_pc"}, f_pc, 32'd0);
    chk({tag, " f_instr"}, f_instr, 32'd0);
    chk({tag, " fetch_misaligned"}, 32'(fetch_misaligned), 32'd0);
  endtask

  // Random phase: reference model tracks the expected request and delivery streams.
  task automatic run_random(input int n_cycles);
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    int          pend_due = 0;
    logic        halted = 1'b0;
    logic [31:0] next_req = RST_PC;
    logic [31:0] exp_fpc = RST_PC;
    logic        chk_fv0 = 1'b0, chk_mis = 1'b0, chk_lat = 1'b0;
    logic [31:0] lat_addr = '0;
    int          xfers = 0;
    logic        grant, xfer, rv, rd, mis;
    logic [31:0] tgt, g_addr;
    logic [1:0]  low;
    int          kind;
    for (int cyc = 0; cyc < n_cycles; cyc++) begin
      rd  = (cyc >= 2) && ($urandom_range(0, 11) == 0);
      kind = $urandom_range(0, 9);
      if (kind < 2)       tgt = ($urandom & 32'h0000_0FFC) | 32'($urandom_range(1, 3));
      else if (kind == 2) tgt = 32'hFFFF_FFF4;
      else                tgt = $urandom & 32'h0000_0FFC;
      low = tgt[1:0];
      mis = (low != 2'b00);
      rv  = pend && (cyc >= pend_due);
      redirect_valid  = rd;
      redirect_target = tgt;
      imem_gnt        = ($urandom_range(0, 2) != 0);
      imem_rvalid     = rv;
      imem_rdata      = rv ? mem_word(pend_addr) : $urandom;
      f_ready         = ($urandom_range(0, 3) != 0);
      #1;
      chk("rnd misaligned_pulse", 32'(fetch_misaligned), 32'(chk_mis));
      if (chk_fv0) chk("rnd f_valid_after_redirect", 32'(f_valid), 32'd0);
      if (chk_lat) begin
        chk("rnd redirect_latency_req", 32'(imem_req), 32'd1);
        chk("rnd redirect_latency_addr", imem_addr, lat_addr);
      end
      if (pend) chk("rnd one_outstanding", 32'(imem_req), 32'd0);
      if (halted) begin
        chk("rnd halt_no_req", 32'(imem_req), 32'd0);
        chk("rnd halt_no_fvalid", 32'(f_valid), 32'd0);
      end else if (imem_req) begin
        chk("rnd req_addr", imem_addr, next_req);
      end
      xfer = f_valid && f_ready;
      if (xfer) begin
        chk("rnd xfer_pc", f_pc, exp_fpc);
        chk("rnd xfer_instr", f_instr, mem_word(f_pc));
        xfers++;
      end
      grant  = imem_req && imem_gnt;
      g_addr = imem_addr;
      @(posedge clk);
      if (rv) pend = 1'b0;
      if (grant) begin
        pend      = 1'b1;
        pend_addr = g_addr;
        pend_due  = cyc + 1 + $urandom_range(0, 2);
        next_req  = next_req + 32'd4;
      end
      if (xfer) exp_fpc = exp_fpc + 32'd4;
      chk_fv0 = rd;
      chk_mis = rd && mis;
      chk_lat = 1'b0;
      if (rd) begin
        if (mis) begin
          halted = 1'b1;
        end else begin
          halted   = 1'b0;
          exp_fpc  = tgt;
          next_req = tgt;
          chk_lat  = !pend;
          lat_addr = tgt;
        end
      end
      @(negedge clk);
    end
    chk("rnd progress", 32'(xfers >= 200), 32'd1);
  endtask

  initial begin
    // rd, tgt, gnt, rv, rva, fr | req, addr, fv, fpc, mis
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1,   1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1,   0, 4, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1,   1, 4, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 4, 1,   0, 8, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1,   1, 8, 1, 4, 0));
    vecs.push_back(mk(0, 0, 0, 1, 8, 1,   0, 12, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 12, 1, 8, 0));
    vecs.push_back(mk(1, 32'h100, 1, 0, 0, 1,         1, 12, 1, 8, 0));
    vecs.push_back(mk(0, 0, 0, 1, 12, 1,              0, 32'h100, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1,               1, 32'h100, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h100, 1,         0, 32'h104, 0, 0, 0));
    vecs.push_back(mk(1, 32'h102, 0, 0, 0, 1,         1, 32'h104, 1, 32'h100, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,               0, 32'h102, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,               0, 32'h102, 0, 0, 0));
    vecs.push_back(mk(1, 32'h200, 0, 0, 0, 1,         0, 32'h102, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1,               1, 32'h200, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h200, 1,         0, 32'h204, 0, 0, 0));
    vecs.push_back(mk(1, 32'hFFFF_FFFC, 0, 0, 0, 1,   1, 32'h204, 1, 32'h200, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1,               1, 32'hFFFF_FFFC, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'hFFFF_FFFC, 1,   0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,               1, 0, 1, 32'hFFFF_FFFC, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1,               1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h300, 0, 0, 0, 1,         0, 4, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,               0, 32'h300, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1,               0, 32'h300, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1,               1, 32'h300, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h300, 1,         0, 32'h304, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,               1, 32'h304, 1, 32'h300, 0));
    vecs.push_back(mk(1, 32'h30A, 1, 0, 0, 1,         1, 32'h304, 0, 0, 0));
    vecs.push_back(mk(1, 32'h400, 0, 0, 0, 1,         0, 32'h30A, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 32'h304, 1,         0, 32'h400, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,               1, 32'h400, 0, 0, 0));

    rst_n = 1'b0;
    drive_idle();
    repeat (3) @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) apply_row(vecs[i], i);

    // Reset while a granted request is still owed: everything returns to reset values at once.
    imem_gnt = 1'b1;
    f_ready  = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("reset_in_flight");
    drive_idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_random(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
